fp_to_int: RTL and testbench

FP_TO_INT -- requirements
Module: fp_to_int

---
 rtl/fp_pkg.sv | 23 ++
 rtl/fp_classify.sv | 38 +++
 rtl/fp_to_int.sv | 172 +++++++++++++++++
 tb/tb_fp_to_int.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision field definitions and operand classes
// for the floating-point conversion and adder blocks.
package fp_pkg;

    localparam int FP_PRECISION = 32;
    localparam int FP_EXPONENT  = 8;
    localparam int FP_FRACTION  = 23;
    localparam int FP_BIAS      = 127;

    // Field extraction positions shared with FP_adder
    localparam int FP_SIGN_BIT  = FP_PRECISION - 1;
    localparam int FP_EXP_LSB   = FP_FRACTION;
    localparam int FP_EXP_MSB   = FP_FRACTION + FP_EXPONENT - 1;
    localparam int FP_MANT_W    = FP_FRACTION + 1;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_e;

endpackage

// File: rtl/fp_classify.sv
// Combinational decode of an IEEE-754 operand into sign, unbiased exponent,
// mantissa with hidden bit, and operand class. Denormals classify as zero.
module fp_classify
    import fp_pkg::*;
#(
    parameter int PRECISION = FP_PRECISION,
    parameter int EXPONENT  = FP_EXPONENT,
    parameter int FRACTION  = FP_FRACTION,
    parameter int BIAS      = FP_BIAS
) (
    input  logic [PRECISION-1:0]       fp_operand,
    output logic                       sign,
    output logic signed [EXPONENT:0]   exp_unbiased,
    output logic [FRACTION:0]          mantissa,
    output logic                       frac_nonzero,
    output fp_class_e                  fp_class
);

    logic [EXPONENT-1:0] exp_field;
    logic [FRACTION-1:0] frac_field;

    always_comb begin
        sign         = fp_operand[PRECISION-1];
        exp_field    = fp_operand[FRACTION +: EXPONENT];
        frac_field   = fp_operand[FRACTION-1:0];
        frac_nonzero = |frac_field;
        mantissa     = {1'b1, frac_field};
        exp_unbiased = $signed({1'b0, exp_field}) - $signed((EXPONENT+1)'(BIAS));

        if (exp_field == '1)
            fp_class = frac_nonzero ? FP_NAN : FP_INF;
        else if (exp_field == '0)
            fp_class = FP_ZERO;
        else
            fp_class = FP_NORM;
    end

endmodule

// File: rtl/fp_to_int.sv
// Three-stage IEEE-754 to signed integer converter, truncating toward zero
// with saturation; the whole pipeline freezes while the result is not taken.
module fp_to_int
    import fp_pkg::*;
#(
    parameter int PRECISION = FP_PRECISION,
    parameter int EXPONENT  = FP_EXPONENT,
    parameter int FRACTION  = FP_FRACTION,
    parameter int BIAS      = FP_BIAS,
    parameter int INT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PRECISION-1:0] fp_operand,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INT_WIDTH-1:0] int_result,
    output logic                 overflow,
    output logic                 invalid,
    output logic                 inexact
);

    localparam int MAG_W = (INT_WIDTH > FRACTION + 1) ? INT_WIDTH : FRACTION + 1;
    localparam logic [FRACTION:0]  MANT_ONES = '1;
    localparam logic [INT_WIDTH-1:0] INT_MAX = {1'b0, {(INT_WIDTH-1){1'b1}}};
    localparam logic [INT_WIDTH-1:0] INT_MIN = {1'b1, {(INT_WIDTH-1){1'b0}}};

    logic stall;

    // Ready is forced high in reset so the first post-reset edge can accept
    always_comb begin
        stall    = out_valid & ~out_ready;
        in_ready = ~stall | ~reset_n;
    end

    logic                     c_sign;
    logic signed [EXPONENT:0] c_exp;
    logic [FRACTION:0]        c_mant;
    logic                     c_frac_nz;
    fp_class_e                c_class;

    fp_classify #(
        .PRECISION (PRECISION),
        .EXPONENT  (EXPONENT),
        .FRACTION  (FRACTION),
        .BIAS      (BIAS)
    ) u_classify (
        .fp_operand   (fp_operand),
        .sign         (c_sign),
        .exp_unbiased (c_exp),
        .mantissa     (c_mant),
        .frac_nonzero (c_frac_nz),
        .fp_class     (c_class)
    );

    logic                     s1_valid;
    logic                     s1_sign;
    logic signed [EXPONENT:0] s1_exp;
    logic [FRACTION:0]        s1_mant;
    logic                     s1_frac_nz;
    fp_class_e                s1_class;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
        end else if (!stall) begin
            s1_valid   <= in_valid;
            s1_sign    <= c_sign;
            s1_exp     <= c_exp;
            s1_mant    <= c_mant;
            s1_frac_nz <= c_frac_nz;
            s1_class   <= c_class;
        end
    end

    logic [INT_WIDTH-1:0] s2_mag_d;
    logic                 s2_big_d;
    logic                 s2_nan_d;
    logic                 s2_inexact_d;
    logic [MAG_W-1:0]     wide;
    logic [FRACTION:0]    lost_mask;
    int                   e_int;
    int unsigned          rsh;
    int unsigned          lsh;

    // Any exponent at or beyond INT_WIDTH is flagged as too big before shifting
    always_comb begin
        s2_big_d     = 1'b0;
        s2_nan_d     = 1'b0;
        s2_inexact_d = 1'b0;
        wide         = '0;
        lost_mask    = '0;
        e_int        = int'(s1_exp);
        rsh          = '0;
        lsh          = '0;
        unique case (s1_class)
            FP_NAN:  s2_nan_d     = 1'b1;
            FP_INF:  s2_big_d     = 1'b1;
            FP_ZERO: s2_inexact_d = s1_frac_nz;
            default: begin
                if (e_int < 0) begin
                    s2_inexact_d = 1'b1;
                end else if (e_int >= INT_WIDTH) begin
                    s2_big_d = 1'b1;
                end else if (e_int <= FRACTION) begin
                    rsh          = $unsigned(FRACTION - e_int);
                    wide         = MAG_W'(s1_mant >> rsh);
                    lost_mask    = ~(MANT_ONES << rsh);
                    s2_inexact_d = |(s1_mant & lost_mask);
                end else begin
                    lsh  = $unsigned(e_int - FRACTION);
                    wide = MAG_W'(s1_mant) << lsh;
                end
            end
        endcase
        s2_mag_d = wide[INT_WIDTH-1:0];
    end

    logic                 s2_valid;
    logic                 s2_sign;
    logic [INT_WIDTH-1:0] s2_mag;
    logic                 s2_big;
    logic                 s2_nan;
    logic                 s2_inexact;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
        end else if (!stall) begin
            s2_valid   <= s1_valid;
            s2_sign    <= s1_sign;
            s2_mag     <= s2_mag_d;
            s2_big     <= s2_big_d;
            s2_nan     <= s2_nan_d;
            s2_inexact <= s2_inexact_d;
        end
    end

    logic                 s3_ovf;
    logic [INT_WIDTH-1:0] s3_res;

    // Negative side tolerates exactly 2^(INT_WIDTH-1)
    always_comb begin
        s3_ovf = ~s2_nan & (s2_big | (s2_sign ? (s2_mag[INT_WIDTH-1] & |s2_mag[INT_WIDTH-2:0])
                                              : s2_mag[INT_WIDTH-1]));
        if (s2_nan)
            s3_res = '0;
        else if (s3_ovf)
            s3_res = s2_sign ? INT_MIN : INT_MAX;
        else
            s3_res = s2_sign ? -s2_mag : s2_mag;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            int_result <= '0;
            overflow   <= 1'b0;
            invalid    <= 1'b0;
            inexact    <= 1'b0;
        end else if (!stall) begin
            out_valid  <= s2_valid;
            int_result <= s2_valid ? s3_res : '0;
            overflow   <= s2_valid & s3_ovf;
            invalid    <= s2_valid & s2_nan;
            inexact    <= s2_valid & s2_inexact & ~s3_ovf & ~s2_nan;
        end
    end

endmodule

// File: tb/tb_fp_to_int.sv
// Bench for fp_to_int: directed vector table, stall and reset sequences,
// and a randomised stream under back-pressure, all scored against a queue.
module tb_fp_to_int;

    typedef struct {
        logic [31:0] fp;
        logic [31:0] res;
        logic        ovf;
        logic        inv;
        logic        inx;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] fp_operand;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] int_result;
    logic        overflow;
    logic        invalid;
    logic        inexact;

    always #5 clk = ~clk;

    fp_to_int #(
        .PRECISION (32),
        .EXPONENT  (8),
        .FRACTION  (23),
        .BIAS      (127),
        .INT_WIDTH (32)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fp_operand (fp_operand),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .int_result (int_result),
        .overflow   (overflow),
        .invalid    (invalid),
        .inexact    (inexact)
    );

    vec_t sb[$];
    vec_t exp_cur;
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic vec_t mk(input logic [31:0] fp, input logic [31:0] res,
                                input logic ovf, input logic inv, input logic inx);
        vec_t v;
        v.fp = fp; v.res = res; v.ovf = ovf; v.inv = inv; v.inx = inx;
        return v;
    endfunction

    // Reference conversion in 64-bit arithmetic for the default single-precision format
    function automatic vec_t model(input logic [31:0] f);
        vec_t            r;
        int              ex;
        int              e;
        longint unsigned m;
        longint unsigned mag;
        bit              s;
        bit              big;
        bit              lost;
        r = mk(f, 32'h0, 1'b0, 1'b0, 1'b0);
        s  = f[31];
        ex = int'(f[30:23]);
        m  = 64'h80_0000 | 64'(f[22:0]);
        if (ex == 255 && f[22:0] != 0) begin
            r.inv = 1'b1;
        end else if (ex == 0) begin
            r.inx = (f[22:0] != 0);
        end else begin
            e    = ex - 127;
            big  = (ex == 255) || (e > 40);
            mag  = 0;
            lost = 1'b0;
            if (!big) begin
                if (e < 0) begin
                    lost = 1'b1;
                end else if (e >= 23) begin
                    mag = m << (e - 23);
                end else begin
                    mag  = m >> (23 - e);
                    lost = ((mag << (23 - e)) != m);
                end
            end
            if (big || (!s && mag > 64'h7FFF_FFFF) || (s && mag > 64'h8000_0000)) begin
                r.ovf = 1'b1;
                r.res = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else begin
                r.res = s ? 32'(-mag) : 32'(mag);
                r.inx = lost;
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin
        vec_t e;
        if (reset_n && out_valid && out_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_output: got res=%h ovf=%0b inv=%0b inx=%0b, required no output",
                         int_result, overflow, invalid, inexact);
            end else begin
                e = sb.pop_front();
                if (int_result !== e.res || overflow !== e.ovf || invalid !== e.inv || inexact !== e.inx) begin
                    miscompares++;
                    $display("FAIL result fp=%h: got res=%h ovf=%0b inv=%0b inx=%0b, required res=%h ovf=%0b inv=%0b inx=%0b",
                             e.fp, int_result, overflow, invalid, inexact, e.res, e.ovf, e.inv, e.inx);
                end
            end
        end
        if (out_valid === 1'b0 && (overflow | invalid | inexact) === 1'b1) begin
            miscompares++;
            $display("FAIL idle_flags: got ovf=%0b inv=%0b inx=%0b, required 0 0 0", overflow, invalid, inexact);
        end
        if (reset_n && in_valid && in_ready)
            sb.push_back(exp_cur);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic send(input vec_t v);
        bit acc;
        acc        = 1'b0;
        fp_operand = v.fp;
        exp_cur    = v;
        in_valid   = 1'b1;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            miscompares++;
            $display("FAIL send_timeout fp=%h: got in_ready=0 for 100 cycles, required acceptance", v.fp);
        end
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 200 && sb.size() != 0; k++)
            @(posedge clk);
        #1;
        check(name, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[$];
        vec_t        stream[$];
        logic [31:0] f;
        int          lat;
        int          stall_cnt;
        bit          done;

        tbl.push_back(mk(32'h3FC0_0000, 32'h0000_0001, 0, 0, 1));
        tbl.push_back(mk(32'hC000_0000, 32'hFFFF_FFFE, 0, 0, 0));
        tbl.push_back(mk(32'h4F00_0000, 32'h7FFF_FFFF, 1, 0, 0));
        tbl.push_back(mk(32'hCF00_0000, 32'h8000_0000, 0, 0, 0));
        tbl.push_back(mk(32'hFF80_0000, 32'h8000_0000, 1, 0, 0));
        tbl.push_back(mk(32'h7FC0_0000, 32'h0000_0000, 0, 1, 0));
        tbl.push_back(mk(32'h0000_0001, 32'h0000_0000, 0, 0, 1));
        tbl.push_back(mk(32'h3F80_0000, 32'h0000_0001, 0, 0, 0));
        tbl.push_back(mk(32'hBF00_0000, 32'h0000_0000, 0, 0, 1));
        tbl.push_back(mk(32'h8000_0000, 32'h0000_0000, 0, 0, 0));
        tbl.push_back(mk(32'h4EFF_FFFF, 32'h7FFF_FF80, 0, 0, 0));
        tbl.push_back(mk(32'hCF00_0001, 32'h8000_0000, 1, 0, 0));
        tbl.push_back(mk(32'h7F80_0000, 32'h7FFF_FFFF, 1, 0, 0));
        tbl.push_back(mk(32'h4B00_0001, 32'h0080_0001, 0, 0, 0));
        tbl.push_back(mk(32'h3FFF_FFFF, 32'h0000_0001, 0, 0, 1));
        tbl.push_back(mk(32'hC049_0FDB, 32'hFFFF_FFFD, 0, 0, 1));
        tbl.push_back(mk(32'h7F7F_FFFF, 32'h7FFF_FFFF, 1, 0, 0));
        tbl.push_back(mk(32'h4F80_0000, 32'h7FFF_FFFF, 1, 0, 0));
        tbl.push_back(mk(32'hFFC0_0001, 32'h0000_0000, 0, 1, 0));
        tbl.push_back(mk(32'h0080_0000, 32'h0000_0000, 0, 0, 1));
        tbl.push_back(mk(32'h807F_FFFF, 32'h0000_0000, 0, 0, 1));

        stream.push_back(mk(32'h3F80_0000, 32'd1, 0, 0, 0));
        stream.push_back(mk(32'h4000_0000, 32'd2, 0, 0, 0));
        stream.push_back(mk(32'h4040_0000, 32'd3, 0, 0, 0));
        stream.push_back(mk(32'h4080_0000, 32'd4, 0, 0, 0));
        stream.push_back(mk(32'h40A0_0000, 32'd5, 0, 0, 0));

        reset_n    = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        fp_operand = '0;
        exp_cur    = mk(32'h0, 32'h0, 0, 0, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("in_ready_during_reset", 32'(in_ready), 32'd1);

        // First input offered on the same edge that reset is released
        @(posedge clk);
        #1;
        reset_n    = 1'b1;
        exp_cur    = tbl[0];
        fp_operand = tbl[0].fp;
        in_valid   = 1'b1;
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_int_result", int_result, 32'd0);
        check("reset_flags", 32'({overflow, invalid, inexact}), 32'd0);
        check("in_ready_after_reset", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            lat++;
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
        end
        check("latency_edges", lat, 32'd3);
        @(posedge clk);
        #1;

        foreach (tbl[i]) send(tbl[i]);
        in_valid = 1'b0;
        drain("drain_table");

        // Five back-to-back inputs; consumer stalls in cycles 4-6
        stall_cnt = 0;
        fork
            begin
                foreach (stream[i]) send(stream[i]);
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            begin
                for (int c = 1; c <= 12; c++) begin
                    @(negedge clk);
                    check($sformatf("in_ready_cycle%0d", c), 32'(in_ready),
                          32'((c >= 4 && c <= 6) ? 0 : 1));
                    if (!in_ready) stall_cnt++;
                end
            end
        join
        check("stall_cycles", stall_cnt, 32'd3);
        drain("drain_stall");

        // Three values in flight, the oldest already on the outputs, then reset
        send(mk(32'h42C8_0000, 32'h0000_0064, 0, 0, 0));
        send(mk(32'h4348_0000, 32'h0000_00C8, 0, 0, 0));
        send(mk(32'h4396_0000, 32'h0000_012C, 0, 0, 0));
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset_n   = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("reset_flush_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        send(mk(32'h40E0_0000, 32'h0000_0007, 0, 0, 0));
        send(mk(32'hC110_0000, 32'hFFFF_FFF7, 0, 0, 0));
        in_valid = 1'b0;
        drain("drain_after_reset");
        repeat (10) @(posedge clk);
        #1;

        // Randomised operands with random consumer back-pressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    case ($urandom_range(0, 9))
                        0:       f = {1'($urandom), 8'h00, 23'($urandom)};
                        1:       f = {1'($urandom), 8'hFF, 23'($urandom_range(0, 1))};
                        default: f = {1'($urandom), 8'($urandom_range(100, 165)), 23'($urandom)};
                    endcase
                    send(model(f));
                end
                in_valid  = 1'b0;
                done      = 1'b1;
                out_ready = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #2;
                    if (!done) out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain("drain_random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
